// File: rtl/vex_wb_reorder.sv
// vex_wb_reorder: ticket-ordered vector writeback buffer retiring one result per cycle in program order.
// Optional VEX_WB_BYPASS_EN retires a head-ticket write directly, one cycle earlier.
module vex_wb_reorder #(
  parameter int DATA_WIDTH         = 32,
  parameter int VECTOR_LANES       = 8,
  parameter int VECTOR_TICKET_BITS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic                               alloc_i,
  output logic [VECTOR_TICKET_BITS-1:0]      alloc_ticket_o,
  output logic                               full_o,
  output logic                               empty_o,
  input  logic                               wr_valid_i,
  input  logic [VECTOR_LANES-1:0]            wr_en_i,
  input  logic [4:0]                         wr_addr_i,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] wr_data_i,
  input  logic [VECTOR_TICKET_BITS-1:0]      wr_ticket_i,
  output logic [VECTOR_LANES-1:0]            vrf_wr_en_o,
  output logic [4:0]                         vrf_wr_addr_o,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] vrf_wr_data_o,
  output logic                               retire_valid_o,
  output logic [VECTOR_TICKET_BITS-1:0]      retire_ticket_o,
  output logic                               err_o
);
  localparam int TB    = VECTOR_TICKET_BITS;
  localparam int DEPTH = 2**TB;
  localparam int LW    = VECTOR_LANES*DATA_WIDTH;

  logic [DEPTH-1:0]        done_q, done_d;
  logic [VECTOR_LANES-1:0] en_q [DEPTH], en_d [DEPTH];
  logic [4:0]              addr_q [DEPTH], addr_d [DEPTH];
  logic [LW-1:0]           data_q [DEPTH], data_d [DEPTH];
  logic [TB-1:0]           head_q, head_d, tail_q, tail_d, rel;
  logic [TB:0]             count_q, count_d;
  logic [VECTOR_LANES-1:0] ven_q, ven_d;
  logic [4:0]              vaddr_q, vaddr_d;
  logic [LW-1:0]           vdata_q, vdata_d;
  logic [TB-1:0]           rt_q, rt_d;
  logic                    rv_q, rv_d, err_q, err_d;
  logic                    alloc_ok, wr_ok, buf_ret, byp, ret;

  // count never exceeds DEPTH, so its MSB alone means full
  assign full_o         = count_q[TB];
  assign empty_o        = count_q == '0;
  assign alloc_ticket_o = tail_q;
  assign rel            = wr_ticket_i - head_q;
  assign alloc_ok       = alloc_i & ~full_o;
  assign wr_ok          = wr_valid_i & ({1'b0, rel} < count_q) & ~done_q[wr_ticket_i];
  assign buf_ret        = ~empty_o & done_q[head_q];
`ifdef VEX_WB_BYPASS_EN
  assign byp = wr_ok & ~buf_ret & (wr_ticket_i == head_q);
`else
  assign byp = 1'b0;
`endif
  assign ret = buf_ret | byp;

  always_comb begin
    done_d  = done_q;
    en_d    = en_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = ret ? head_q + TB'(1) : head_q;
    tail_d  = alloc_ok ? tail_q + TB'(1) : tail_q;
    count_d = count_q + {{TB{1'b0}}, alloc_ok} - {{TB{1'b0}}, ret};
    if (ret) done_d[head_q] = 1'b0;
    if (alloc_ok) done_d[tail_q] = 1'b0;
    if (wr_ok && !byp) begin
      done_d[wr_ticket_i] = 1'b1;
      en_d[wr_ticket_i]   = wr_en_i;
      addr_d[wr_ticket_i] = wr_addr_i;
      data_d[wr_ticket_i] = wr_data_i;
    end
    ven_d   = ret ? (byp ? wr_en_i : en_q[head_q]) : '0;
    vaddr_d = ret ? (byp ? wr_addr_i : addr_q[head_q]) : vaddr_q;
    vdata_d = ret ? (byp ? wr_data_i : data_q[head_q]) : vdata_q;
    rv_d    = ret;
    rt_d    = ret ? head_q : rt_q;
    err_d   = err_q | (wr_valid_i & ~wr_ok & ~flush_i);
    if (flush_i) begin
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ven_d   = '0;
      vaddr_d = '0;
      vdata_d = '0;
      rv_d    = 1'b0;
      rt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ven_q   <= '0;
      vaddr_q <= '0;
      vdata_q <= '0;
      rv_q    <= 1'b0;
      rt_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ven_q   <= ven_d;
      vaddr_q <= vaddr_d;
      vdata_q <= vdata_d;
      rv_q    <= rv_d;
      rt_q    <= rt_d;
      err_q   <= err_d;
    end
  end

  // payload is qualified by done, so it needs no reset
  always_ff @(posedge clk) begin
    en_q   <= en_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign vrf_wr_en_o     = ven_q;
  assign vrf_wr_addr_o   = vaddr_q;
  assign vrf_wr_data_o   = vdata_q;
  assign retire_valid_o  = rv_q;
  assign retire_ticket_o = rt_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_vex_wb_reorder.sv
// tb_vex_wb_reorder: directed vector table plus fill, async reset and head-latency sequences.
module tb_vex_wb_reorder;
  localparam int DW = 32;
  localparam int NL = 8;
  localparam int TB = 4;
  localparam int LW = DW*NL;
`ifdef VEX_WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk, rst, flush_i, alloc_i, full_o, empty_o, wr_valid_i;
  logic [TB-1:0] alloc_ticket_o, wr_ticket_i, retire_ticket_o;
  logic [NL-1:0] wr_en_i, vrf_wr_en_o;
  logic [4:0]    wr_addr_i, vrf_wr_addr_o;
  logic [LW-1:0] wr_data_i, vrf_wr_data_o;
  logic          retire_valid_o, err_o;

  vex_wb_reorder #(.DATA_WIDTH(DW), .VECTOR_LANES(NL), .VECTOR_TICKET_BITS(TB)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .alloc_i(alloc_i),
    .alloc_ticket_o(alloc_ticket_o), .full_o(full_o), .empty_o(empty_o),
    .wr_valid_i(wr_valid_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_ticket_i(wr_ticket_i),
    .vrf_wr_en_o(vrf_wr_en_o), .vrf_wr_addr_o(vrf_wr_addr_o), .vrf_wr_data_o(vrf_wr_data_o),
    .retire_valid_o(retire_valid_o), .retire_ticket_o(retire_ticket_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fl, al, wv, en, addr, tk;
    int rv, rt, ven, va, full, empty, at, err;
  } vec_t;

  vec_t v [29];
  int pass = 0;
  int total = 0;

  function automatic logic [LW-1:0] mk(input logic [4:0] a);
    return {NL{3'b101, a, 24'h00c0de}};
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  task automatic chkd(input string n, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic drive(input int fl, input int al, input int wv, input int en, input int addr, input int tk);
    flush_i     = fl != 0;
    alloc_i     = al != 0;
    wr_valid_i  = wv != 0;
    wr_en_i     = NL'(en);
    wr_addr_i   = 5'(addr);
    wr_ticket_i = TB'(tk);
    wr_data_i   = mk(5'(addr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fl al wv en addr tk | rv rt ven va full empty at err
    v[0]  = '{0,1,0,0,0,0,        0,0,0,0,0,1,0,0};
    v[1]  = '{0,1,0,0,0,0,        0,0,0,0,0,0,1,0};
    v[2]  = '{0,1,0,0,0,0,        0,0,0,0,0,0,2,0};
    v[3]  = '{0,0,1,'hff,5,2,     0,0,0,0,0,0,3,0};
    v[4]  = '{0,0,1,'hff,6,0,     0,0,0,0,0,0,3,0};
    v[5]  = '{0,0,1,'h0f,7,1,     0,0,0,0,0,0,3,0};
    v[6]  = '{0,0,0,0,0,0,        1,0,'hff,6,0,0,3,0};
    v[7]  = '{0,0,0,0,0,0,        1,1,'h0f,7,0,0,3,0};
    v[8]  = '{0,0,0,0,0,0,        1,2,'hff,5,0,1,3,0};
    v[9]  = '{0,0,0,0,0,0,        0,2,0,5,0,1,3,0};
    v[10] = '{0,1,0,0,0,0,        0,2,0,5,0,1,3,0};
    v[11] = '{0,0,1,0,9,3,        0,2,0,5,0,0,4,0};
    v[12] = '{0,0,1,'hff,10,3,    0,2,0,5,0,0,4,0};
    v[13] = '{0,0,1,'hff,11,5,    1,3,0,9,0,1,4,1};
    v[14] = '{0,0,0,0,0,0,        0,3,0,9,0,1,4,1};
    v[15] = '{0,1,0,0,0,0,        0,3,0,9,0,1,4,1};
    v[16] = '{0,1,0,0,0,0,        0,3,0,9,0,0,5,1};
    v[17] = '{0,1,0,0,0,0,        0,3,0,9,0,0,6,1};
    v[18] = '{0,1,0,0,0,0,        0,3,0,9,0,0,7,1};
    v[19] = '{0,0,1,'hff,12,5,    0,3,0,9,0,0,8,1};
    v[20] = '{0,0,1,'hff,13,6,    0,3,0,9,0,0,8,1};
    v[21] = '{1,1,1,'hff,14,7,    0,3,0,9,0,0,8,1};
    v[22] = '{0,0,0,0,0,0,        0,0,0,0,0,1,0,1};
    v[23] = '{0,1,0,0,0,0,        0,0,0,0,0,1,0,1};
    v[24] = '{0,0,0,0,0,0,        0,0,0,0,0,0,1,1};
    v[25] = '{0,0,1,'hff,15,0,    0,0,0,0,0,0,1,1};
    v[26] = '{0,0,0,0,0,0,        0,0,0,0,0,0,1,1};
    v[27] = '{0,0,0,0,0,0,        1,0,'hff,15,0,1,1,1};
    v[28] = '{0,0,0,0,0,0,        0,0,0,15,0,1,1,1};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (v[i]) begin
      drive(v[i].fl, v[i].al, v[i].wv, v[i].en, v[i].addr, v[i].tk);
      #3;
      chk($sformatf("r%0d retire_valid", i), int'(retire_valid_o), v[i].rv);
      chk($sformatf("r%0d retire_ticket", i), int'(retire_ticket_o), v[i].rt);
      chk($sformatf("r%0d vrf_en", i), int'(vrf_wr_en_o), v[i].ven);
      chk($sformatf("r%0d vrf_addr", i), int'(vrf_wr_addr_o), v[i].va);
      chkd($sformatf("r%0d vrf_data", i), vrf_wr_data_o, v[i].va == 0 ? '0 : mk(5'(v[i].va)));
      chk($sformatf("r%0d full", i), int'(full_o), v[i].full);
      chk($sformatf("r%0d empty", i), int'(empty_o), v[i].empty);
      chk($sformatf("r%0d alloc_ticket", i), int'(alloc_ticket_o), v[i].at);
      chk($sformatf("r%0d err", i), int'(err_o), v[i].err);
      tick();
    end

    // asynchronous reset between clock edges
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("async_rst addr", int'(vrf_wr_addr_o), 0);
    chkd("async_rst data", vrf_wr_data_o, '0);
    chk("async_rst err", int'(err_o), 0);
    chk("async_rst empty", int'(empty_o), 1);
    chk("async_rst alloc_ticket", int'(alloc_ticket_o), 1 - 1);
    rst = 1'b0;
    tick();

    // fill all 16 tickets, then one refused alloc
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      #3;
      chk($sformatf("fill%0d alloc_ticket", i), int'(alloc_ticket_o), i);
      chk($sformatf("fill%0d full", i), int'(full_o), 0);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0);
    #3;
    chk("full full", int'(full_o), 1);
    tick();
    // drain in order, one retire per cycle
    for (int i = 0; i < 16 + LAT; i++) begin
      drive(0, 0, i < 16 ? 1 : 0, 'hff, i + 1, i);
      #3;
      if (i == 0) begin
        chk("over_alloc tail", int'(alloc_ticket_o), 0);
        chk("over_alloc full", int'(full_o), 1);
      end
      if (i >= LAT) begin
        chk($sformatf("drain%0d valid", i), int'(retire_valid_o), 1);
        chk($sformatf("drain%0d ticket", i), int'(retire_ticket_o), i - LAT);
        chk($sformatf("drain%0d addr", i), int'(vrf_wr_addr_o), i - LAT + 1);
        chkd($sformatf("drain%0d data", i), vrf_wr_data_o, mk(5'(i - LAT + 1)));
      end
      tick();
    end
    drive(0, 1, 0, 0, 0, 0);
    #3;
    chk("drained empty", int'(empty_o), 1);
    chk("drained valid", int'(retire_valid_o), 0);
    chk("wrap alloc_ticket", int'(alloc_ticket_o), 0);
    tick();

    // head write latency
    drive(0, 0, 1, 'h3c, 20, 0);
    #3;
    chk("lat alloc_ticket", int'(alloc_ticket_o), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("lat n+1 valid", int'(retire_valid_o), int'(LAT == 1));
    tick();
    #3;
    chk("lat n+2 valid", int'(retire_valid_o), int'(LAT == 2));
    chk("lat ticket", int'(retire_ticket_o), 0);
    chk("lat addr", int'(vrf_wr_addr_o), 20);
    chk("lat err", int'(err_o), 0);
    tick();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/vex_wb_reorder.md
# vex_wb_reorder

Ticket-ordered writeback retirement buffer for the vector execution path. Hands out tickets in program order to the vector issue stage and accepts out-of-order lane writeback from the vector execution unit (per-lane enables, destination, data, ticket). Retires exactly one buffered result per cycle, in ticket order, to the vector register file write port. Also reports the retired ticket to the scoreboard.

## Interface
- DATA_WIDTH, 32, width of one lane element
- VECTOR_LANES, 8, number of lanes
- VECTOR_TICKET_BITS, 4, ticket width; buffer depth DEPTH = 2**VECTOR_TICKET_BITS
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous pipeline flush
- alloc_i  in  1  issue stage requests a ticket this cycle
- alloc_ticket_o  out  VECTOR_TICKET_BITS  ticket granted (tail pointer); valid when alloc_i & !full_o
- full_o  out  1  no free tickets (count == DEPTH)
- empty_o  out  1  no tickets outstanding (count == 0)
- wr_valid_i  in  1  an execution result arrives this cycle
- wr_en_i  in  VECTOR_LANES  per-lane write enables of that result; all zero is legal (fully masked op)
- wr_addr_i  in  5  destination vector register
- wr_data_i  in  VECTOR_LANES*DATA_WIDTH  lane data, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- wr_ticket_i  in  VECTOR_TICKET_BITS  ticket of the result
- vrf_wr_en_o  out  VECTOR_LANES  register file lane write enables (registered)
- vrf_wr_addr_o  out  5  register file destination (registered)
- vrf_wr_data_o  out  VECTOR_LANES*DATA_WIDTH  register file data (registered)
- retire_valid_o  out  1  one ticket retired this cycle (registered)
- retire_ticket_o  out  VECTOR_TICKET_BITS  ticket retired (registered)
- err_o  out  1  sticky protocol error flag

## Operation
- State: DEPTH slots {done, en, addr, data}; head, tail pointers (VECTOR_TICKET_BITS, natural wrap); count (VECTOR_TICKET_BITS+1 bits).
- Alloc: alloc_i & !full_o -> tail increments, count increments, slot[tail].done cleared. Alloc while full_o is ignored; tail and count stay unchanged.
- Write: wr_valid_i stores en/addr/data into slot[wr_ticket_i] and sets done.
- Write error: if the ticket is not outstanding, or the slot already has done=1, the write is dropped and err_o is set.
- Outstanding ticket: (wr_ticket_i - head) mod DEPTH < count.
- Retire: if count != 0 and slot[head].done, the slot contents are registered onto the vrf_*/retire_* outputs.
  - Same cycle: done is cleared, head increments, count decrements.
  - Otherwise: retire_valid_o=0 and vrf_wr_en_o=0; addr/data hold their last value.
- A retired entry with en all zero still asserts retire_valid_o, with vrf_wr_en_o=0.
- Same-cycle alloc and retire: count is unchanged. full_o is based on the registered count, so alloc is refused even when a retire happens in the same cycle.
- Flush:
  - Clears all done bits and sets head=tail=count=0.
  - Alloc, write and retire in the flush cycle are discarded.
  - Registered outputs go to 0 the next cycle. err_o is not cleared.
- err_o is cleared only by rst.

## Timing
- Reset values: vrf_wr_en_o=0, vrf_wr_addr_o=0, vrf_wr_data_o=0, retire_valid_o=0, retire_ticket_o=0, err_o=0, full_o=0, empty_o=1, alloc_ticket_o=0.
- Reset clears all done bits and pointers.
- alloc_ticket_o, full_o and empty_o are combinational from registered state.
- Without bypass: a write at cycle N to the head ticket appears on the outputs in cycle N+2.
- Throughput: one retire per cycle sustained, when done entries are back-to-back.
- One write and one alloc accepted per cycle. A write and an alloc to the same slot index cannot collide, because a just-allocated ticket is not yet outstanding.
- Reset asserted mid-operation returns every output to its reset value asynchronously.

## Configuration
- VEX_WB_BYPASS_EN defined:
  - A write in cycle N whose ticket equals head, while slot[head].done=0 and count != 0, is retired directly.
  - Its outputs appear in cycle N+1; the slot is never marked done.
  - Buffered head entries keep priority; only one retire per cycle.
- Undefined: all writes pass through the slot array, with 2-cycle minimum latency.

## Test plan
- Reset, then alloc 3 tickets (0,1,2); write tickets in order 2,0,1 with addr 5,6,7 -> retire order tickets 0,1,2, addr 6,7,5, on consecutive cycles after ticket 1's write.
- Fill: 16 allocs -> full_o=1; 17th alloc leaves tail unchanged. Retire all 16 -> empty_o=1, head wraps to 0, and the next alloc grants ticket 0.
- Fully masked result (wr_en_i=0) for head ticket -> retire_valid_o=1, vrf_wr_en_o=0.
- Double write to ticket 3, or a write to a non-outstanding ticket -> err_o=1 and sticky; retire order unaffected.
- Flush with 4 outstanding, 2 done, plus a same-cycle write -> no retire afterwards, empty_o=1, next alloc grants ticket 0.
- Head write at cycle N -> retire_valid_o at N+1 with VEX_WB_BYPASS_EN, at N+2 without it.
